// File: rtl/laser_mem_mapper_if.sv
// CPU, download and SDRAM signal bundle for the laser memory mapper.
// The mapper uses the slave view; the CPU/SDRAM side uses the master view.
interface laser_mem_mapper_if #(
   parameter int ADDR_W = 25
);
   logic [15:0]       cpu_addr;
   logic [7:0]        cpu_dout;
   logic              cpu_mreq_n;
   logic              cpu_iorq_n;
   logic              cpu_rd_n;
   logic              cpu_wr_n;
   logic              cpu_wait_n;
   logic [7:0]        cpu_din;
   logic              io_cs;
   logic              dl_active;
   logic [ADDR_W-1:0] dl_addr;
   logic [7:0]        dl_data;
   logic              dl_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic              mem_we;
   logic              mem_req;
   logic              mem_ack;
   logic [7:0]        mem_dout;
   logic              wp_hit;
   logic              dl_overrun;

   modport slave (
      input  cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
      input  dl_active, dl_addr, dl_data, dl_wr, mem_ack, mem_dout,
      output cpu_wait_n, cpu_din, io_cs, mem_addr, mem_din, mem_we, mem_req,
      output wp_hit, dl_overrun
   );

   modport master (
      output cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
      output dl_active, dl_addr, dl_data, dl_wr, mem_ack, mem_dout,
      input  cpu_wait_n, cpu_din, io_cs, mem_addr, mem_din, mem_we, mem_req,
      input  wp_hit, dl_overrun
   );
endinterface

// File: rtl/laser_mem_mapper.sv
// Banked memory mapper between the T80 bus and the SDRAM controller, with
// I/O-programmable page registers, ROM write protection and a download path.
module laser_mem_mapper #(
   parameter int         SLOTS     = 4,
   parameter int         PAGE_BITS = 4,
   parameter int         ADDR_W    = 25,
   parameter int         RAM_FIRST = 4,
   parameter int         RAM_LAST  = 7,
   parameter int         IO_PAGE   = 2,
   parameter logic [7:0] BANK_PORT = 8'h40
) (
   input logic               F14M,
   input logic               RESET,
   laser_mem_mapper_if.slave bus
);
   localparam int SB = $clog2(SLOTS);
   localparam int OW = 16 - SB;
   localparam logic [PAGE_BITS-1:0] RAM_LO = PAGE_BITS'(RAM_FIRST);
   localparam logic [PAGE_BITS-1:0] RAM_HI = PAGE_BITS'(RAM_LAST);
   localparam logic [PAGE_BITS-1:0] IO_PG  = PAGE_BITS'(IO_PAGE);

   typedef enum logic [1:0] {IDLE, CPU_REQ, DL_REQ, DONE} state_t;

   state_t              state_r;
   logic [PAGE_BITS-1:0] page_r [SLOTS];
   logic                io_wr_d_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [7:0]          mem_din_r;
   logic                mem_we_r;
   logic                mem_req_r;
   logic [7:0]          cpu_din_r;
   logic                wp_hit_r;
   logic                dl_overrun_r;

   logic [SB-1:0]        slot_s;
   logic [PAGE_BITS-1:0] pg_s;
   logic [ADDR_W-1:0]    phys_s;
   logic                 is_ram_s;
   logic                 is_io_s;
   logic                 mem_acc_s;
   logic                 dl_go_s;
   logic                 cpu_go_s;
   logic                 io_acc_s;
   logic                 wp_go_s;
   logic                 launch_cpu_s;
   logic                 io_wr_s;
   logic [7:0]           port_off_s;
   logic                 port_hit_s;
   logic [SB-1:0]        port_slot_s;

   // Address decode, launch qualification and bank-port match.
   always_comb begin
      slot_s       = bus.cpu_addr[15:OW];
      pg_s         = page_r[slot_s];
      phys_s       = ADDR_W'({pg_s, bus.cpu_addr[OW-1:0]});
      is_ram_s     = (pg_s >= RAM_LO) && (pg_s <= RAM_HI);
      is_io_s      = (pg_s == IO_PG);
      mem_acc_s    = !bus.cpu_mreq_n && (!bus.cpu_rd_n || !bus.cpu_wr_n);
      dl_go_s      = bus.dl_active && bus.dl_wr;
      cpu_go_s     = !bus.dl_active && mem_acc_s && !is_io_s;
      io_acc_s     = !bus.dl_active && mem_acc_s && is_io_s;
      wp_go_s      = cpu_go_s && !bus.cpu_wr_n && !is_ram_s;
      // RESET gating keeps WAIT released while the CPU strobes are still asserted.
      launch_cpu_s = !RESET && (state_r == IDLE) && !dl_go_s && cpu_go_s && !wp_go_s;
      io_wr_s      = !bus.cpu_iorq_n && !bus.cpu_wr_n;
      port_off_s   = bus.cpu_addr[7:0] - BANK_PORT;
      port_hit_s   = io_wr_s && !io_wr_d_r && (port_off_s < 8'(SLOTS));
      port_slot_s  = port_off_s[SB-1:0];
   end

   assign bus.cpu_wait_n = !(launch_cpu_s || (state_r == CPU_REQ));
   assign bus.io_cs      = mem_acc_s && is_io_s;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_din    = mem_din_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_req    = mem_req_r;
   assign bus.cpu_din    = cpu_din_r;
   assign bus.wp_hit     = wp_hit_r;
   assign bus.dl_overrun = dl_overrun_r;

   // Page registers: written once on the leading cycle of an I/O write strobe.
   always_ff @(posedge F14M or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < SLOTS; i++) begin
            page_r[i] <= PAGE_BITS'(i);
         end
         io_wr_d_r <= 1'b0;
      end else begin
         io_wr_d_r <= io_wr_s;
         if (port_hit_s) begin
            page_r[port_slot_s] <= bus.cpu_dout[PAGE_BITS-1:0];
         end
      end
   end

   // Transaction FSM with registered SDRAM request and CPU-side outputs.
   always_ff @(posedge F14M or posedge RESET) begin
      if (RESET) begin
         state_r      <= IDLE;
         mem_addr_r   <= '0;
         mem_din_r    <= 8'h00;
         mem_we_r     <= 1'b0;
         mem_req_r    <= 1'b0;
         cpu_din_r    <= 8'hFF;
         wp_hit_r     <= 1'b0;
         dl_overrun_r <= 1'b0;
      end else begin
         wp_hit_r <= 1'b0;
         // Any download strobe outside IDLE cannot be accepted and is lost.
         if (bus.dl_wr && (state_r != IDLE)) begin
            dl_overrun_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (dl_go_s) begin
                  mem_addr_r <= bus.dl_addr;
                  mem_din_r  <= bus.dl_data;
                  mem_we_r   <= 1'b1;
                  mem_req_r  <= 1'b1;
                  state_r    <= DL_REQ;
               end else if (wp_go_s) begin
                  wp_hit_r <= 1'b1;
                  state_r  <= DONE;
               end else if (cpu_go_s) begin
                  mem_addr_r <= phys_s;
                  mem_din_r  <= bus.cpu_dout;
                  mem_we_r   <= !bus.cpu_wr_n;
                  mem_req_r  <= 1'b1;
                  state_r    <= CPU_REQ;
               end else if (io_acc_s) begin
                  state_r <= DONE;
               end else begin
                  state_r <= IDLE;
               end
            end
            CPU_REQ: begin
               if (bus.mem_ack) begin
                  mem_req_r <= 1'b0;
                  mem_we_r  <= 1'b0;
                  if (!mem_we_r) begin
                     cpu_din_r <= bus.mem_dout;
                  end
                  state_r <= DONE;
               end else begin
                  state_r <= CPU_REQ;
               end
            end
            DL_REQ: begin
               if (bus.mem_ack) begin
                  mem_req_r <= 1'b0;
                  mem_we_r  <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  state_r <= DL_REQ;
               end
            end
            DONE: begin
               if (bus.cpu_mreq_n) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_laser_mem_mapper.sv
// Directed-vector bench for laser_mem_mapper with a simple SDRAM responder.
`timescale 1ns/1ps
module tb_laser_mem_mapper;
   logic clk;
   logic rst;

   laser_mem_mapper_if #(.ADDR_W(25)) bus ();

   laser_mem_mapper u_dut (
      .F14M  (clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   int n_vec      = 0;
   int n_miscmp   = 0;
   int ack_delay  = 3;
   logic [7:0] rd_data = 8'h00;
   int req_count  = 0;
   int unstable   = 0;
   logic [24:0] cap_addr;
   logic [7:0]  cap_din;
   logic        cap_we;
   logic        prev_req = 1'b0;
   int          ack_cnt  = 0;

   logic acc_wait0, acc_wait_after, acc_io, acc_wait_all, acc_req_seen, acc_hi_during;
   logic [7:0] acc_din;
   int acc_wp;
   int base;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SDRAM responder: counts requests, captures them, acks after ack_delay cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.mem_req && !prev_req) begin
            req_count++;
            cap_addr = bus.mem_addr;
            cap_din  = bus.mem_din;
            cap_we   = bus.mem_we;
         end else if (bus.mem_req && (bus.mem_addr != cap_addr || bus.mem_din != cap_din
                                      || bus.mem_we != cap_we)) begin
            unstable++;
         end
         prev_req = bus.mem_req;
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
         end else if (bus.mem_req) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
               bus.mem_ack  = 1'b1;
               bus.mem_dout = rd_data;
               ack_cnt      = 0;
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   task automatic cpu_access(input logic [15:0] a, input logic wr, input logic [7:0] d,
                             input logic exp_req);
      int n;
      @(negedge clk);
      bus.cpu_addr   = a;
      bus.cpu_dout   = d;
      bus.cpu_mreq_n = 1'b0;
      bus.cpu_rd_n   = wr;
      bus.cpu_wr_n   = !wr;
      #1;
      acc_wait0     = bus.cpu_wait_n;
      acc_io        = bus.io_cs;
      acc_wp        = 0;
      acc_wait_all  = bus.cpu_wait_n;
      acc_req_seen  = 1'b0;
      acc_hi_during = 1'b0;
      acc_wait_after = 1'b0;
      acc_din       = 8'h00;
      if (exp_req) begin
         n = 0;
         do begin
            @(negedge clk); #1;
            n++;
            acc_wp += int'(bus.wp_hit);
            acc_hi_during |= bus.cpu_wait_n;
         end while (!bus.mem_ack && n < 40);
         check_eq("ack_seen", {31'd0, bus.mem_ack}, 32'd1);
         @(negedge clk); #1;
         acc_wait_after = bus.cpu_wait_n;
         acc_din        = bus.cpu_din;
      end else begin
         repeat (4) begin
            @(negedge clk); #1;
            acc_wp += int'(bus.wp_hit);
            acc_wait_all &= bus.cpu_wait_n;
            acc_req_seen |= bus.mem_req;
         end
      end
      bus.cpu_mreq_n = 1'b1;
      bus.cpu_rd_n   = 1'b1;
      bus.cpu_wr_n   = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.dl_addr = a;
      bus.dl_data = d;
      bus.dl_wr   = 1'b1;
      @(negedge clk);
      bus.dl_wr   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.cpu_addr = 16'h0000; bus.cpu_dout = 8'h00;
      bus.cpu_mreq_n = 1'b1; bus.cpu_iorq_n = 1'b1; bus.cpu_rd_n = 1'b1; bus.cpu_wr_n = 1'b1;
      bus.dl_active = 1'b0; bus.dl_addr = 25'd0; bus.dl_data = 8'h00; bus.dl_wr = 1'b0;
      bus.mem_ack = 1'b0; bus.mem_dout = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_req",   {31'd0, bus.mem_req}, 32'd0);
      check_eq("rst_we",    {31'd0, bus.mem_we}, 32'd0);
      check_eq("rst_addr",  {7'd0, bus.mem_addr}, 32'd0);
      check_eq("rst_din",   {24'd0, bus.mem_din}, 32'd0);
      check_eq("rst_cpudin", {24'd0, bus.cpu_din}, 32'hFF);
      check_eq("rst_wait",  {31'd0, bus.cpu_wait_n}, 32'd1);
      check_eq("rst_wp",    {31'd0, bus.wp_hit}, 32'd0);
      check_eq("rst_ovr",   {31'd0, bus.dl_overrun}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Read through slot 1 (page 1)
      ack_delay = 3; rd_data = 8'h5A; base = req_count;
      cpu_access(16'h4123, 1'b0, 8'h00, 1'b1);
      check_eq("rd_addr", {7'd0, cap_addr}, 32'h0004123);
      check_eq("rd_we", {31'd0, cap_we}, 32'd0);
      check_eq("rd_wait0", {31'd0, acc_wait0}, 32'd0);
      check_eq("rd_wait_during", {31'd0, acc_hi_during}, 32'd0);
      check_eq("rd_wait_after", {31'd0, acc_wait_after}, 32'd1);
      check_eq("rd_cpudin", {24'd0, acc_din}, 32'h5A);
      check_eq("rd_iocs", {31'd0, acc_io}, 32'd0);
      check_eq("rd_reqs", req_count - base, 32'd1);

      // OUT (41h): data changes mid-strobe; only the leading cycle writes
      @(negedge clk);
      bus.cpu_addr = 16'h0041; bus.cpu_dout = 8'h05;
      bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0;
      @(negedge clk);
      bus.cpu_dout = 8'h07;
      repeat (2) @(negedge clk);
      #1;
      check_eq("out_wait", {31'd0, bus.cpu_wait_n}, 32'd1);
      bus.cpu_iorq_n = 1'b1; bus.cpu_wr_n = 1'b1;
      // OUT (43h),F6: upper nibble ignored, slot 3 -> page 6
      @(negedge clk);
      bus.cpu_addr = 16'h0043; bus.cpu_dout = 8'hF6;
      bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0;
      @(negedge clk);
      bus.cpu_iorq_n = 1'b1; bus.cpu_wr_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("out_noreq", req_count - base, 32'd1);

      base = req_count;
      cpu_access(16'h4000, 1'b1, 8'h77, 1'b1);
      check_eq("wr_addr", {7'd0, cap_addr}, 32'h0014000);
      check_eq("wr_we", {31'd0, cap_we}, 32'd1);
      check_eq("wr_din", {24'd0, cap_din}, 32'h77);
      check_eq("wr_reqs", req_count - base, 32'd1);

      base = req_count;
      cpu_access(16'hC001, 1'b1, 8'h3E, 1'b1);
      check_eq("wr3_addr", {7'd0, cap_addr}, 32'h0018001);
      check_eq("wr3_reqs", req_count - base, 32'd1);

      // ROM write: blocked, single wp_hit pulse
      base = req_count;
      cpu_access(16'h0010, 1'b1, 8'hEE, 1'b0);
      check_eq("wp_pulses", acc_wp, 32'd1);
      check_eq("wp_wait0", {31'd0, acc_wait0}, 32'd1);
      check_eq("wp_wait", {31'd0, acc_wait_all}, 32'd1);
      check_eq("wp_req", {31'd0, acc_req_seen}, 32'd0);
      check_eq("wp_reqs", req_count - base, 32'd0);

      // ROM read with the earliest possible ack
      ack_delay = 1; rd_data = 8'hC7; base = req_count;
      cpu_access(16'h0010, 1'b0, 8'h00, 1'b1);
      check_eq("romrd_addr", {7'd0, cap_addr}, 32'h0000010);
      check_eq("romrd_din", {24'd0, acc_din}, 32'hC7);
      check_eq("romrd_wait_after", {31'd0, acc_wait_after}, 32'd1);
      check_eq("romrd_wp", acc_wp, 32'd0);

      // Mapped I/O page
      base = req_count;
      cpu_access(16'h8005, 1'b0, 8'h00, 1'b0);
      check_eq("io_cs", {31'd0, acc_io}, 32'd1);
      check_eq("io_req", {31'd0, acc_req_seen}, 32'd0);
      check_eq("io_wait", {31'd0, acc_wait_all}, 32'd1);
      check_eq("io_reqs", req_count - base, 32'd0);

      // Downloads, spaced apart
      ack_delay = 3;
      @(negedge clk);
      bus.dl_active = 1'b1;
      for (int k = 0; k < 3; k++) begin
         base = req_count;
         dl_write(25'h1ABC000 + 25'(k), 8'hA0 + 8'(k));
         repeat (18) @(negedge clk);
         #1;
         check_eq("dl_addr", {7'd0, cap_addr}, 32'h1ABC000 + k);
         check_eq("dl_din", {24'd0, cap_din}, 32'hA0 + k);
         check_eq("dl_we", {31'd0, cap_we}, 32'd1);
         check_eq("dl_reqs", req_count - base, 32'd1);
         check_eq("dl_ovr0", {31'd0, bus.dl_overrun}, 32'd0);
      end

      // CPU strobe ignored while downloading
      base = req_count;
      cpu_access(16'h4000, 1'b0, 8'h00, 1'b0);
      check_eq("dlcpu_wait", {31'd0, acc_wait_all}, 32'd1);
      check_eq("dlcpu_req", {31'd0, acc_req_seen}, 32'd0);

      // Back-to-back download strobes with a slow ack
      ack_delay = 10; base = req_count;
      @(negedge clk);
      bus.dl_addr = 25'h00F00F0; bus.dl_data = 8'h3C; bus.dl_wr = 1'b1;
      @(negedge clk);
      bus.dl_addr = 25'h00F00F1; bus.dl_data = 8'hC3;
      @(negedge clk);
      bus.dl_wr = 1'b0;
      #1;
      check_eq("ovr_set", {31'd0, bus.dl_overrun}, 32'd1);
      repeat (15) @(negedge clk);
      check_eq("ovr_addr", {7'd0, cap_addr}, 32'h00F00F0);
      check_eq("ovr_din", {24'd0, cap_din}, 32'h3C);
      check_eq("ovr_reqs", req_count - base, 32'd1);
      bus.dl_active = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("ovr_sticky", {31'd0, bus.dl_overrun}, 32'd1);

      // Reset while a CPU request is outstanding
      ack_delay = 100;
      @(negedge clk);
      bus.cpu_addr = 16'h4123; bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
      check_eq("pre_rst_wait", {31'd0, bus.cpu_wait_n}, 32'd0);
      rst = 1'b1;
      #1;
      check_eq("rstmid_req", {31'd0, bus.mem_req}, 32'd0);
      check_eq("rstmid_wait", {31'd0, bus.cpu_wait_n}, 32'd1);
      check_eq("rstmid_ovr", {31'd0, bus.dl_overrun}, 32'd0);
      bus.cpu_mreq_n = 1'b1; bus.cpu_rd_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      ack_delay = 2; rd_data = 8'h99; base = req_count;
      cpu_access(16'h4000, 1'b0, 8'h00, 1'b1);
      check_eq("post_addr1", {7'd0, cap_addr}, 32'h0004000);
      check_eq("post_din", {24'd0, acc_din}, 32'h99);
      check_eq("post_reqs", req_count - base, 32'd1);
      cpu_access(16'hC000, 1'b0, 8'h00, 1'b1);
      check_eq("post_addr3", {7'd0, cap_addr}, 32'h000C000);
      cpu_access(16'h8005, 1'b0, 8'h00, 1'b0);
      check_eq("post_io", {31'd0, acc_io}, 32'd1);
      check_eq("req_stable", unstable, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule

// File: doc/laser_mem_mapper.md
Name: laser_mem_mapper

Overview:
- Parametrised banked memory mapper between the T80 CPU bus and the SDRAM controller.
- Successor to the fixed 4x4-bit bank-register scheme: configurable slot count, page width and RAM/ROM/IO page ranges.
- Adds I/O-port programmable page registers, ROM write protection, a req/ack SDRAM handshake with CPU WAIT generation, and a download path with overrun detection.
- Sits between T80s/data_io and sdram; clocked by F14M.

Parameters:
- SLOTS, 4, number of CPU address windows; power of two, 2..16. SB = log2(SLOTS); offset width OW = 16-SB.
- PAGE_BITS, 4, width of each page register.
- ADDR_W, 25, physical SDRAM address width; must be >= PAGE_BITS+OW.
- RAM_FIRST, 4, lowest writable page number.
- RAM_LAST, 7, highest writable page number.
- IO_PAGE, 2, page number decoded as memory-mapped I/O (never sent to SDRAM).
- BANK_PORT, 8'h40, I/O port of slot 0's page register; slot i is at BANK_PORT+i.

Ports:
- F14M  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n  in  1 each  CPU strobes, active low.
- cpu_wait_n  out  1  WAIT to CPU; low stalls the CPU.
- cpu_din  out  8  registered read data to CPU.
- io_cs  out  1  mapped-I/O select.
- dl_active  in  1  download in progress.
- dl_addr  in  ADDR_W  download address.
- dl_data  in  8  download data.
- dl_wr  in  1  single-cycle download write strobe.
- mem_addr  out  ADDR_W  SDRAM address.
- mem_din  out  8  SDRAM write data.
- mem_we  out  1  SDRAM write enable.
- mem_req  out  1  SDRAM request.
- mem_ack  in  1  one-cycle SDRAM completion.
- mem_dout  in  8  SDRAM read data, valid when mem_ack=1.
- wp_hit  out  1  one-cycle pulse on a write to a ROM page.
- dl_overrun  out  1  sticky flag; a dl_wr was dropped.

Behaviour:

Reset (RESET=1, asynchronous):
- page[i] = i.
- state = IDLE.
- mem_req=0, mem_we=0, mem_addr=0, mem_din=0, cpu_din=8'hFF.
- cpu_wait_n=1, wp_hit=0, dl_overrun=0.

Decode:
- slot = cpu_addr[15:OW]; pg = page[slot].
- phys = zero-extend {pg, cpu_addr[OW-1:0]} to ADDR_W.
- is_ram = RAM_FIRST <= pg <= RAM_LAST.
- is_io = (pg == IO_PAGE).

io_cs:
- Combinational: !cpu_mreq_n & is_io & (!cpu_rd_n | !cpu_wr_n).

Page register writes:
- !cpu_iorq_n & !cpu_wr_n with cpu_addr[7:0] == BANK_PORT+i (i < SLOTS): page[i] <= cpu_dout[PAGE_BITS-1:0].
- The register is written once per strobe, on the first cycle it is low.
- Upper data bits are ignored.

FSM states: IDLE, CPU_REQ, DL_REQ, DONE.

IDLE:
- If dl_active & dl_wr: latch dl_addr/dl_data into mem_addr/mem_din; mem_we=1, mem_req=1; go to DL_REQ.
- Else if !dl_active, a memory access is active (!cpu_mreq_n & (!cpu_rd_n | !cpu_wr_n)) and !is_io:
  - Write to a non-RAM page: no request; wp_hit pulses for 1 cycle; go to DONE.
  - Otherwise: mem_addr=phys, mem_din=cpu_dout, mem_we=!cpu_wr_n, mem_req=1; go to CPU_REQ.
- IO-page accesses go straight to DONE.

CPU_REQ:
- mem_req, mem_addr, mem_din and mem_we are held stable until mem_ack.
- On mem_ack: mem_req=0, mem_we=0; for reads cpu_din <= mem_dout; go to DONE.
- mem_ack may arrive as early as the cycle after mem_req rises; there is no timeout.

DL_REQ:
- On mem_ack: mem_req=0, mem_we=0; go to IDLE.
- A dl_wr arriving while in DL_REQ is dropped and sets dl_overrun=1.
- dl_overrun clears only on RESET.

DONE:
- Return to IDLE when cpu_mreq_n=1, so there is exactly one SDRAM transaction per CPU access.

cpu_wait_n:
- Combinationally 0 in the IDLE cycle that launches a CPU_REQ.
- 0 throughout CPU_REQ.
- 1 in the cycle after mem_ack, and 1 otherwise.

Downloads:
- dl_active asserted while in CPU_REQ: the CPU transaction still completes.
- dl_wr in that window is dropped and sets dl_overrun.
- A CPU strobe while dl_active=1 is ignored (cpu_wait_n stays 1).

Concurrent events:
- A page write and a memory decode in the same cycle: the decode uses the old page value.

Reset mid-transaction:
- Immediate return to the reset state.
- mem_req is dropped without waiting for ack.
- The SDRAM controller must tolerate an abandoned request.

Test Plan:
- After reset, CPU read 16'h4123: mem_addr=25'h0004123, mem_we=0, wait_n low until ack; mem_dout=8'h5A, then cpu_din=8'h5A and wait_n=1 one cycle after ack.
- OUT (8'h41),8'h05, then write 8'h77 to 16'h4000: mem_addr=25'h0014000, mem_we=1, mem_din=8'h77, exactly one mem_req per access.
- Write to 16'h0010 with page[0]=0 (ROM): no mem_req, wp_hit pulses 1 cycle, wait_n stays 1, SDRAM untouched.
- page[2]=2, read 16'h8005: io_cs=1, mem_req=0, wait_n=1.
- dl_active=1 with dl_wr every 20 cycles, ack at 3 cycles: each write forwarded with its dl_addr/dl_data and dl_overrun=0. Then dl_wr twice in 2 cycles with ack delayed 10 cycles: second write dropped, dl_overrun=1.
- RESET asserted while in CPU_REQ: mem_req=0 and wait_n=1 immediately; page registers back to 0..3; next access is a fresh request.
